// File: rtl/linear_proj_out_collector_if.sv
// Tile stream from the multi-matmul array into the output collector.
// The master produces tiles; the slave (collector) signals when it can take one.
interface linear_proj_out_collector_if #(
  parameter int TILE_W = 512
) ();
  logic              in_valid;
  logic [TILE_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/linear_proj_out_collector.sv
// Collects matmul output tiles and serializes each into one BRAM write per
// matmul module, using row-major C addresses; pulses done after the last tile.
module linear_proj_out_collector #(
  parameter int WIDTH_OUT      = 16,
  parameter int BLOCK_SIZE     = 2,
  parameter int NUM_CORES_A    = 2,
  parameter int NUM_CORES_B    = 1,
  parameter int TOTAL_MODULES  = 4,
  parameter int ROW_SIZE_MAT_C = 1,
  parameter int COL_SIZE_MAT_C = 1,
  localparam int SLICE_W  = WIDTH_OUT * BLOCK_SIZE * BLOCK_SIZE * NUM_CORES_A * NUM_CORES_B,
  localparam int TILE_W   = SLICE_W * TOTAL_MODULES,
  localparam int MAX_FLAG = ROW_SIZE_MAT_C * COL_SIZE_MAT_C,
  localparam int NUM_WR   = MAX_FLAG * TOTAL_MODULES,
  localparam int ADDR_W   = (NUM_WR > 1) ? $clog2(NUM_WR) : 1,
  localparam int FLAG_W   = $clog2(MAX_FLAG + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  linear_proj_out_collector_if.slave   tile_if,
  output logic                         wr_en,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [SLICE_W-1:0]           wr_data,
  output logic [FLAG_W-1:0]            flag_cnt,
  output logic                         busy,
  output logic                         done
);

  localparam int M_W   = $clog2(TOTAL_MODULES + 1);
  localparam int ROW_W = (ROW_SIZE_MAT_C > 1) ? $clog2(ROW_SIZE_MAT_C) : 1;
  localparam int COL_W = (COL_SIZE_MAT_C > 1) ? $clog2(COL_SIZE_MAT_C) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [TILE_W-1:0]   tile_q, tile_d;
  logic [M_W-1:0]      m_q, m_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [FLAG_W-1:0]   flag_cnt_q, flag_cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [SLICE_W-1:0]  wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [ADDR_W-1:0]   tile_base;
  logic [SLICE_W-1:0]  cur_slice;

  assign tile_base = ADDR_W'(int'(row_q) * COL_SIZE_MAT_C * TOTAL_MODULES
                             + int'(col_q) * TOTAL_MODULES);

  always_comb begin
    cur_slice = '0;
    for (int i = 0; i < TOTAL_MODULES; i++) begin
      if (int'(m_q) == i) cur_slice = tile_q[i*SLICE_W +: SLICE_W];
    end
  end

  // Slice 0 is issued on the handshake edge so the first write lands one
  // cycle later; the extra drain step with m == TOTAL_MODULES closes the tile.
  always_comb begin
    state_d    = state_q;
    tile_d     = tile_q;
    m_d        = m_q;
    row_d      = row_q;
    col_d      = col_q;
    flag_cnt_d = flag_cnt_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ACCEPT;
          flag_cnt_d = '0;
          row_d      = '0;
          col_d      = '0;
          busy_d     = 1'b1;
        end
      end
      S_ACCEPT: begin
        if (tile_if.in_valid) begin
          tile_d    = tile_if.in_data;
          m_d       = M_W'(1);
          wr_en_d   = 1'b1;
          wr_addr_d = tile_base;
          wr_data_d = tile_if.in_data[SLICE_W-1:0];
          state_d   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (int'(m_q) < TOTAL_MODULES) begin
          wr_en_d   = 1'b1;
          wr_addr_d = tile_base + ADDR_W'(m_q);
          wr_data_d = cur_slice;
          m_d       = m_q + 1'b1;
        end else begin
          flag_cnt_d = flag_cnt_q + 1'b1;
          if (col_q == COL_W'(COL_SIZE_MAT_C - 1)) begin
            col_d = '0;
            row_d = (row_q == ROW_W'(ROW_SIZE_MAT_C - 1)) ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (int'(flag_cnt_q) == MAX_FLAG - 1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_ACCEPT;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tile_q     <= '0;
      m_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      flag_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tile_q     <= tile_d;
      m_q        <= m_d;
      row_q      <= row_d;
      col_q      <= col_d;
      flag_cnt_q <= flag_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tile_if.in_ready = (state_q == S_ACCEPT);
  assign wr_en            = wr_en_q;
  assign wr_addr          = wr_addr_q;
  assign wr_data          = wr_data_q;
  assign flag_cnt         = flag_cnt_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_linear_proj_out_collector.sv
// Randomized bench for linear_proj_out_collector (2x3 tiles per run), checked
// cycle by cycle against a latency-rule reference model of the collector.
module tb_linear_proj_out_collector;

  localparam int TM       = 4;
  localparam int ROWS     = 2;
  localparam int COLS     = 3;
  localparam int SLICE_W  = 128;
  localparam int TILE_W   = SLICE_W * TM;
  localparam int MAX_FLAG = ROWS * COLS;
  localparam int ADDR_W   = 5;
  localparam int FLAG_W   = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [SLICE_W-1:0] wr_data;
  logic [FLAG_W-1:0]  flag_cnt;
  logic               busy;
  logic               done;

  linear_proj_out_collector_if #(.TILE_W(TILE_W)) tile_if ();

  linear_proj_out_collector #(
    .ROW_SIZE_MAT_C (ROWS),
    .COL_SIZE_MAT_C (COLS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .tile_if  (tile_if),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .flag_cnt (flag_cnt),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [SLICE_W-1:0] obs,
                             input logic [SLICE_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: a run is a start cycle plus a list of handshake cycles;
  // every output follows from those by the latency rules alone.
  typedef struct {
    int                 cyc;
    int                 addr;
    logic [SLICE_W-1:0] data;
  } wr_t;

  wr_t                wr_q[$];
  int                 hs_list[$];
  bit                 armed = 0;
  bit                 in_run = 0;
  int                 run_start = 0;
  int                 n_acc = 0;
  int                 last_hs = 0;
  logic [ADDR_W-1:0]  held_addr = '0;
  logic [SLICE_W-1:0] held_data = '0;

  always @(negedge clk) begin
    bit  exp_ready, exp_done, exp_busy, exp_wr, start_ok;
    int  n_flag, r, c;
    wr_t w;
    exp_ready = 0;
    exp_done  = 0;
    if (armed) begin
      exp_ready = in_run && cyc > run_start && n_acc < MAX_FLAG &&
                  (n_acc == 0 || cyc >= last_hs + TM + 1);
      exp_done  = in_run && n_acc == MAX_FLAG && cyc == last_hs + TM + 1;
      exp_busy  = in_run && cyc > run_start && !exp_done;
      exp_wr    = wr_q.size() > 0 && wr_q[0].cyc == cyc;
      if (exp_wr) begin
        held_addr = ADDR_W'(wr_q[0].addr);
        held_data = wr_q[0].data;
        void'(wr_q.pop_front());
      end
      n_flag = 0;
      foreach (hs_list[i]) if (hs_list[i] + TM + 1 <= cyc) n_flag++;
      checkOutput("in_ready", tile_if.in_ready, exp_ready);
      checkOutput("busy", busy, exp_busy);
      checkOutput("done", done, exp_done);
      checkOutput("wr_en", wr_en, exp_wr);
      checkOutput("wr_addr", wr_addr, held_addr);
      checkOutput("wr_data", wr_data, held_data);
      checkOutput("flag_cnt", flag_cnt, n_flag);
    end
    if (!rst_n) begin
      armed  = 1;
      in_run = 0;
      n_acc  = 0;
      wr_q.delete();
      hs_list.delete();
      held_addr = '0;
      held_data = '0;
    end else if (armed) begin
      start_ok = !in_run && start;
      if (exp_ready && tile_if.in_valid) begin
        r = n_acc / COLS;
        c = n_acc % COLS;
        for (int m = 0; m < TM; m++) begin
          w.cyc  = cyc + 1 + m;
          w.addr = r * COLS * TM + c * TM + m;
          w.data = tile_if.in_data[m*SLICE_W +: SLICE_W];
          wr_q.push_back(w);
        end
        hs_list.push_back(cyc);
        last_hs = cyc;
        n_acc++;
      end
      if (exp_done) in_run = 0;
      if (start_ok) begin
        in_run    = 1;
        run_start = cyc;
        n_acc     = 0;
        hs_list.delete();
      end
    end
  end

  function automatic logic [TILE_W-1:0] randTile();
    logic [TILE_W-1:0] t;
    for (int i = 0; i < TILE_W / 32; i++) t[i*32 +: 32] = $urandom;
    return t;
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    waitCycles(1);
    start = 1'b0;
  endtask

  // Presents one tile and returns one cycle after its handshake edge.
  task automatic applyStimulus(input logic [TILE_W-1:0] data, input bit drop_valid);
    bit hs;
    hs = 0;
    tile_if.in_valid = 1'b1;
    tile_if.in_data  = data;
    for (int n = 0; n < 40 && !hs; n++) begin
      @(negedge clk);
      hs = tile_if.in_ready;
      waitCycles(1);
    end
    if (!hs) checkOutput("handshake_timeout", 0, 1);
    if (drop_valid) tile_if.in_valid = 1'b0;
  endtask

  initial begin
    logic [TILE_W-1:0] pat;
    tile_if.in_valid = 1'b0;
    tile_if.in_data  = '0;
    for (int m = 0; m < TM; m++) pat[m*SLICE_W +: SLICE_W] = SLICE_W'(m + 1);
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(2);

    // Valid asserted before start must not be captured.
    tile_if.in_valid = 1'b1;
    tile_if.in_data  = pat;
    waitCycles(3);
    pulseStart();
    applyStimulus(pat, 1'b0);
    for (int k = 1; k < MAX_FLAG; k++) applyStimulus(randTile(), k == MAX_FLAG - 1);
    waitCycles(TM + 4);

    // Stalls, plus start pulses during drain and in the done cycle.
    pulseStart();
    waitCycles(2);
    for (int k = 0; k < MAX_FLAG; k++) begin
      applyStimulus(randTile(), 1'b1);
      if (k == 0) pulseStart();
      if (k == 1) waitCycles(7);
      else if (k == MAX_FLAG - 1) begin
        waitCycles(TM);
        pulseStart();
      end else waitCycles($urandom_range(0, 3));
    end
    waitCycles(5);

    // Reset in the middle of the third tile's drain, then a fresh run.
    pulseStart();
    for (int k = 0; k < 3; k++) applyStimulus(randTile(), k == 2);
    waitCycles(1);
    rst_n = 1'b0;
    waitCycles(1);
    rst_n = 1'b1;
    waitCycles(3);
    pulseStart();
    for (int k = 0; k < MAX_FLAG; k++) begin
      applyStimulus(randTile(), 1'b1);
      waitCycles($urandom_range(0, 2));
    end
    waitCycles(TM + 4);

    checkOutput("pending_writes", wr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
